// File: rtl/backprop_node_to_input_layer.sv
`default_nettype none
// ============================================================================
// Module   : backprop_node_to_input_layer
// Purpose  : Backward pass of an input-layer node. Buffers the three forward
//            input samples, takes the back-propagated error delta, applies the
//            activation derivative, and streams lr * delta' * x_i for i = 0..2.
// Options  : BACKPROP_LRELU_DERIV_EN - when defined, applies the leaky-ReLU
//            derivative using i_preact; otherwise the derivative is linear.
// Revision : 1.0 - initial release
// ============================================================================

// FP32 multiplier, 7-cycle latency (input register + 6 result stages).
// Denormal operands are treated as zero; results round to nearest even.
module multiplier_floating_point32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        valid_out
);
    localparam int STAGES = 7;

    logic [31:0]        a_q, b_q;
    logic               v_q;
    logic [31:0]        res_q [STAGES-1];
    logic [STAGES-2:0]  vld_q;

    logic [47:0]        w_prod;
    logic [23:0]        w_mant, w_mant_r;
    logic               w_rnd, w_sign;
    logic signed [9:0]  w_exp;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [31:0]        w_res;

    // Product, normalisation, rounding and special-value handling
    always_comb begin
        w_sign   = a_q[31] ^ b_q[31];
        w_a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
        w_b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
        w_a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
        w_b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
        w_a_zero = ~(|a_q[30:23]);
        w_b_zero = ~(|b_q[30:23]);
        w_prod   = 48'({1'b1, a_q[22:0]}) * 48'({1'b1, b_q[22:0]});
        if (w_prod[47]) begin
            w_mant = {1'b0, w_prod[46:24]};
            w_rnd  = w_prod[23] & ((|w_prod[22:0]) | w_prod[24]);
            w_exp  = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd126;
        end else begin
            w_mant = {1'b0, w_prod[45:23]};
            w_rnd  = w_prod[22] & ((|w_prod[21:0]) | w_prod[23]);
            w_exp  = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - 10'sd127;
        end
        w_mant_r = w_mant + {23'd0, w_rnd};
        if (w_mant_r[23]) begin
            w_exp = w_exp + 10'sd1;
        end
        if (w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_b_inf & w_a_zero)) begin
            w_res = 32'h7FC0_0000;
        end else if (w_a_inf | w_b_inf) begin
            w_res = {w_sign, 8'hFF, 23'd0};
        end else if (w_a_zero | w_b_zero) begin
            w_res = {w_sign, 31'd0};
        end else if (w_exp >= 10'sd255) begin
            w_res = {w_sign, 8'hFF, 23'd0};
        end else if (w_exp <= 10'sd0) begin
            w_res = {w_sign, 31'd0};
        end else begin
            w_res = {w_sign, w_exp[7:0], w_mant_r[22:0]};
        end
    end

    // Operand capture followed by a plain result delay line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            v_q   <= 1'b0;
            vld_q <= '0;
            for (int i = 0; i < STAGES - 1; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            a_q      <= a;
            b_q      <= b;
            v_q      <= valid_in;
            res_q[0] <= w_res;
            vld_q[0] <= v_q;
            for (int i = 1; i < STAGES - 1; i++) begin
                res_q[i] <= res_q[i-1];
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign result    = res_q[STAGES-2];
    assign valid_out = vld_q[STAGES-2];
endmodule

module backprop_node_to_input_layer #(
    parameter int DATA_WIDTH  = 32,
    parameter int LRELU_SHIFT = 7,
    parameter int LR_SHIFT    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_delta_valid,
    input  logic [DATA_WIDTH-1:0] i_delta,
    input  logic [DATA_WIDTH-1:0] i_preact,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last
);
    typedef enum logic [2:0] {
        LOAD0      = 3'd0,
        LOAD1      = 3'd1,
        LOAD2      = 3'd2,
        WAIT_DELTA = 3'd3,
        ISSUE      = 3'd4,
        DRAIN      = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] x_q [3];
    logic [DATA_WIDTH-1:0] delta_q, w_delta_d;
    logic [1:0]            iss_cnt_q, out_cnt_q;
    logic [DATA_WIDTH-1:0] mul_a_q, mul_b_q;
    logic                  mul_v_q;
    logic [DATA_WIDTH-1:0] w_mul_res;
    logic                  w_mul_vout, w_mul_v;
    logic [DATA_WIDTH-1:0] o_data_q;
    logic                  o_valid_q, o_last_q;
    logic                  w_ready, w_take_x, w_take_d;
    logic                  w_unused;

    // Power-of-two down-scaling by exponent adjustment; underflow flushes to signed zero
    function automatic logic [31:0] pow2scale(input logic [31:0] v, input int s);
        logic [7:0] e;
        e = v[30:23];
        if (e == 8'hFF) begin
            return v;
        end else if (e == 8'h00 || int'(e) <= s) begin
            return {v[31], 31'd0};
        end else begin
            return {v[31], e - 8'(s), v[22:0]};
        end
    endfunction

`ifdef BACKPROP_LRELU_DERIV_EN
    assign w_delta_d = i_preact[DATA_WIDTH-1] ? pow2scale(i_delta, LRELU_SHIFT) : i_delta;
`else
    assign w_delta_d = i_delta;
`endif
    // Only the sign of the pre-activation matters, and only in the leaky-ReLU build
    assign w_unused = ^{i_preact, 32'(LRELU_SHIFT)};

    assign w_ready  = (state_q == LOAD0) || (state_q == LOAD1) ||
                      (state_q == LOAD2) || (state_q == WAIT_DELTA);
    assign w_take_x = i_valid && w_ready && (state_q != WAIT_DELTA);
    assign w_take_d = i_delta_valid && (state_q == WAIT_DELTA);
    // Results still in the multiplier pipe are dropped while reset is held
    assign w_mul_v  = w_mul_vout & rst_n;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD0:      if (w_take_x) state_d = LOAD1;
            LOAD1:      if (w_take_x) state_d = LOAD2;
            LOAD2:      if (w_take_x) state_d = WAIT_DELTA;
            WAIT_DELTA: if (w_take_d) state_d = ISSUE;
            ISSUE:      if (iss_cnt_q == 2'd2) state_d = DRAIN;
            DRAIN:      if (o_last_q) state_d = LOAD0;
            default:    state_d = LOAD0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD0;
        end else begin
            state_q <= state_d;
        end
    end

    // Sample buffer; contents are meaningless until written, so it has no reset
    always_ff @(posedge clk) begin
        if (w_take_x) begin
            x_q[state_q[1:0]] <= i_data;
        end
    end

    // Derivative capture, multiplier issue and scaled result registration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delta_q   <= '0;
            iss_cnt_q <= 2'd0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_v_q   <= 1'b0;
            out_cnt_q <= 2'd0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
        end else begin
            if (w_take_d) begin
                delta_q <= w_delta_d;
            end
            iss_cnt_q <= (state_q == ISSUE) ? iss_cnt_q + 2'd1 : 2'd0;
            mul_v_q   <= (state_q == ISSUE);
            mul_a_q   <= delta_q;
            mul_b_q   <= x_q[iss_cnt_q];
            o_valid_q <= w_mul_v;
            o_last_q  <= w_mul_v && (out_cnt_q == 2'd2);
            if (w_mul_v) begin
                o_data_q  <= pow2scale(w_mul_res, LR_SHIFT);
                out_cnt_q <= (out_cnt_q == 2'd2) ? 2'd0 : out_cnt_q + 2'd1;
            end
        end
    end

    multiplier_floating_point32 u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (mul_v_q),
        .a         (mul_a_q),
        .b         (mul_b_q),
        .result    (w_mul_res),
        .valid_out (w_mul_vout)
    );

    assign o_ready = w_ready;
    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
endmodule
`default_nettype wire
